operand2_select_gen: RTL
========================

Name: operand2_select_gen

Overview:
- Decode-stage producer for the operand2 path.
- Accepts fetched SPARC V8 instruction words through a valid/ready handshake and classifies each by format.
- Emits the 4-bit operand2 select code, the 22-bit immediate field, and the rs2 address consumed by the operand2 handler in the execute stage.
- Buffers results in a 2-entry skid FIFO, so fetch sees a registered ready and execute can stall freely.

Parameters:
- PC_W, 32, width of the program-counter tag carried with each instruction.
- DEPTH, 2, skid buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word and PC present
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  synchronous pipeline flush (branch mispredict or trap)
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage consumes head
- out_is  out  4  operand2 select code
- out_imm  out  22  immediate field
- out_rs2  out  5  rs2 register address (instr[4:0])
- out_pc  out  PC_W  PC tag of head
- out_illegal  out  1  head instruction is unimplemented or reserved

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO count is 0; out_valid=0; in_ready=1.
  - out_is=4'b1000; out_imm, out_rs2, out_pc and out_illegal are 0.
- Select code encoding (shared package):
  - IS_SETHI=0000: imm22<<10.
  - IS_DISP22=0100: sign-extended disp22.
  - IS_REG=1000: use R.
  - IS_SIMM13=1001: sign-extended simm13.
  - IS_SHREG=1010: R[4:0].
  - IS_SHIMM=1011: imm[4:0].
- Decode (combinational on in_instr, captured on accept):
  - op=00, op2=100: SETHI → IS_SETHI, imm=instr[21:0].
  - op=00, op2=010 or 110: Bicc or FBfcc → IS_DISP22, imm=instr[21:0].
  - op=00, op2 in {000,001,011,101,111}: illegal=1, IS_REG, imm=0.
  - op=01: CALL → IS_REG, imm=0, illegal=0. Operand2 is unused for CALL.
  - op=10 or 11, op3 in {100101,100110,100111} (shifts):
    - i=0 → IS_SHREG, imm=0.
    - i=1 → IS_SHIMM, imm={17'b0, instr[4:0]}.
  - op=10 or 11, other op3:
    - i=0 → IS_REG, imm=0.
    - i=1 → IS_SIMM13, imm=simm13 sign-extended to 22 bits.
  - out_rs2 is always instr[4:0].
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2). It is a registered function of count, with no combinational path from out_ready.
  - Latency: an instruction accepted at edge k is visible on out_* after edge k when the FIFO was empty. When the FIFO was not empty it waits behind older entries, strictly in order.
  - Push and pop in the same cycle: count is unchanged and the data order is preserved.
  - With count=2 the push is blocked (in_ready=0). A pop in that cycle frees space only from the next cycle.
- Outputs:
  - out_* are driven from the head entry register.
  - They hold stable while out_valid && !out_ready.
  - When out_valid=0 they hold their last value.
- Flush:
  - Highest priority.
  - At the edge where flush=1, count goes to 0 and any same-cycle accept or pop is discarded.
  - out_valid=0 and in_ready=1 from the next cycle.
- Reset mid-operation: all entries are lost immediately and the block resumes in the reset state.

Decomposition:
- Package sparc_op2_pkg:
  - IS_* localparams.
  - op, op2 and op3 field constants, including OP3_SLL, OP3_SRL, OP3_SRA.
  - An op2_entry_t struct {is, imm, rs2, pc, illegal}.
- Sub-module op2_decode: the pure combinational instruction → op2_entry_t classifier.
- The top level holds the 2-entry skid FIFO and handshake logic.

Test Plan:
- SETHI: in_instr=0x03000010 → out_is=0000, out_imm=0x000010, illegal=0, one cycle after accept.
- Register and immediate ADD:
  - 0x86004002 → out_is=1000, out_rs2=2.
  - Then 0x86007FFF → out_is=1001, out_imm=0x3FFFFF.
- Shift and branch:
  - 0x87286005 (SLL imm) → out_is=1011, out_imm=0x000005.
  - 0x10BFFFFC (BA −4) → out_is=0100, out_imm=0x3FFFFC.
- Backpressure:
  - Hold out_ready=0 and offer 3 instructions → in_ready drops after 2 accepts.
  - Release out_ready → entries drain in order; the third instruction is then accepted.
- Flush: with 2 entries buffered and in_valid=1, pulse flush → next cycle out_valid=0, in_ready=1, and the offered instruction is dropped.
- Illegal and reset:
  - 0x00000000 (UNIMP) → out_illegal=1.
  - Assert rst_n=0 mid-stream → out_valid falls with no clock edge, and the reset values above hold.

Source files
------------

// File: rtl/sparc_op2_pkg.sv
// Shared operand2 select codes, SPARC V8 field constants and the decoded entry
// type exchanged between the decode classifier and the skid FIFO.
package sparc_op2_pkg;

  localparam logic [3:0] IS_SETHI  = 4'b0000;
  localparam logic [3:0] IS_DISP22 = 4'b0100;
  localparam logic [3:0] IS_REG    = 4'b1000;
  localparam logic [3:0] IS_SIMM13 = 4'b1001;
  localparam logic [3:0] IS_SHREG  = 4'b1010;
  localparam logic [3:0] IS_SHIMM  = 4'b1011;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_FBFCC = 3'b110;

  localparam logic [5:0] OP3_SLL = 6'b100101;
  localparam logic [5:0] OP3_SRL = 6'b100110;
  localparam logic [5:0] OP3_SRA = 6'b100111;

  // Width of the PC tag held inside an entry.
  localparam int OP2_PC_W = 32;

  typedef struct packed {
    logic [3:0]          is;
    logic [21:0]         imm;
    logic [4:0]          rs2;
    logic [OP2_PC_W-1:0] pc;
    logic                illegal;
  } op2_entry_t;

  localparam op2_entry_t OP2_RESET_ENTRY = '{is: IS_REG, imm: '0, rs2: '0, pc: '0, illegal: 1'b0};

endpackage

// File: rtl/op2_decode.sv
// Pure combinational classifier: one SPARC V8 instruction word to its
// operand2 select code, immediate, rs2 address and illegal flag.
module op2_decode
  import sparc_op2_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [OP2_PC_W-1:0] pc,
  output op2_entry_t          entry
);

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       i_bit;

  assign op    = instr[31:30];
  assign op2   = instr[24:22];
  assign op3   = instr[24:19];
  assign i_bit = instr[13];

  always_comb begin
    entry         = OP2_RESET_ENTRY;
    entry.rs2     = instr[4:0];
    entry.pc      = pc;
    unique case (op)
      OP_FMT2: begin
        if (op2 == OP2_SETHI) begin
          entry.is  = IS_SETHI;
          entry.imm = instr[21:0];
        end else if (op2 == OP2_BICC || op2 == OP2_FBFCC) begin
          entry.is  = IS_DISP22;
          entry.imm = instr[21:0];
        end else begin
          entry.illegal = 1'b1;
        end
      end
      OP_CALL: entry.is = IS_REG;
      OP_ARITH, OP_MEM: begin
        if (op3 == OP3_SLL || op3 == OP3_SRL || op3 == OP3_SRA) begin
          entry.is  = i_bit ? IS_SHIMM : IS_SHREG;
          entry.imm = i_bit ? {17'b0, instr[4:0]} : 22'b0;
        end else begin
          entry.is  = i_bit ? IS_SIMM13 : IS_REG;
          entry.imm = i_bit ? {{9{instr[12]}}, instr[12:0]} : 22'b0;
        end
      end
      default: entry.is = IS_REG;
    endcase
  end

endmodule

// File: rtl/operand2_select_gen.sv
// Decode-stage operand2 producer: classifies accepted instructions and
// buffers them in a 2-entry skid FIFO with a registered in_ready.
module operand2_select_gen
  import sparc_op2_pkg::*;
#(
  parameter int PC_W  = OP2_PC_W,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_is,
  output logic [21:0]     out_imm,
  output logic [4:0]      out_rs2,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  op2_entry_t dec_entry;
  op2_entry_t head_reg, head_next;
  op2_entry_t tail_reg, tail_next;
  logic [1:0] count_reg, count_next;
  logic       in_ready_reg;
  logic       push, pop;

  op2_decode u_decode (
    .instr (in_instr),
    .pc    (OP2_PC_W'(in_pc)),
    .entry (dec_entry)
  );

  assign push = in_valid && in_ready_reg;
  assign pop  = (count_reg != 2'd0) && out_ready;

  // head_reg is the output register; tail_reg only holds the second entry.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && pop) begin
      if (count_reg == 2'd1) begin
        head_next = dec_entry;
      end else begin
        head_next = tail_reg;
        tail_next = dec_entry;
      end
    end else if (push) begin
      if (count_reg == 2'd0) head_next = dec_entry;
      else                   tail_next = dec_entry;
      count_next = count_reg + 2'd1;
    end else if (pop) begin
      if (count_reg == 2'd2) head_next = tail_reg;
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= 2'd0;
      in_ready_reg <= 1'b1;
      head_reg     <= OP2_RESET_ENTRY;
      tail_reg     <= OP2_RESET_ENTRY;
    end else begin
      count_reg    <= count_next;
      in_ready_reg <= (count_next != FULL);
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (count_reg != 2'd0);
  assign out_is      = head_reg.is;
  assign out_imm     = head_reg.imm;
  assign out_rs2     = head_reg.rs2;
  assign out_pc      = PC_W'(head_reg.pc);
  assign out_illegal = head_reg.illegal;

endmodule
